// File: rtl/acc_activation_drain_if.sv
// Unified-buffer write port driven by the activation drain: valid/ready with word index and data.
interface acc_activation_drain_if #(
    parameter int OUT_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_addr;
    logic [OUT_W-1:0] out_data;

    modport master (output out_valid, out_addr, out_data, input out_ready);
    modport slave  (input out_valid, out_addr, out_data, output out_ready);
endinterface

// File: rtl/acc_activation_drain.sv
// Snapshots the eight accumulator words on the rising edge of 'full', requantises them
// (optional ReLU, rounding shift, saturation) and streams them out. Macro: ACT_RELU_EN.
module acc_activation_drain #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   full,
    input  logic signed [IN_W-1:0] acc_mem_0,
    input  logic signed [IN_W-1:0] acc_mem_1,
    input  logic signed [IN_W-1:0] acc_mem_2,
    input  logic signed [IN_W-1:0] acc_mem_3,
    input  logic signed [IN_W-1:0] acc_mem_4,
    input  logic signed [IN_W-1:0] acc_mem_5,
    input  logic signed [IN_W-1:0] acc_mem_6,
    input  logic signed [IN_W-1:0] acc_mem_7,
    input  logic [3:0]             shift,
    acc_activation_drain_if.master wr,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;

    state_t                   state, state_nx;
    logic                     full_q;
    logic                     cap_ev;
    logic                     capture;
    logic                     hs;
    logic [2:0]               idx, idx_nx;
    logic [3:0]               sh_q;
    logic [7:0][IN_W-1:0]     acc_in;
    logic [7:0][IN_W-1:0]     cap_buf;

    // One extra bit of headroom so the rounding add can never wrap.
    function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] x, input logic [3:0] sh);
        logic signed [IN_W:0] xe, rnd, t, r;
        logic [OUT_W-1:0]     y;
        xe = {x[IN_W-1], x};
`ifdef ACT_RELU_EN
        if (x[IN_W-1]) xe = '0;
`endif
        rnd = '0;
        if (sh != 4'd0) rnd = (IN_W+1)'(1) << (sh - 4'd1);
        t = xe + rnd;
        r = t >>> sh;
        if (r > SAT_MAX)      y = SAT_MAX[OUT_W-1:0];
        else if (r < SAT_MIN) y = SAT_MIN[OUT_W-1:0];
        else                  y = r[OUT_W-1:0];
        return y;
    endfunction

    assign acc_in = {acc_mem_7, acc_mem_6, acc_mem_5, acc_mem_4,
                     acc_mem_3, acc_mem_2, acc_mem_1, acc_mem_0};
    assign cap_ev = full & ~full_q;
    assign hs     = (state == SEND) & wr.out_ready;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        capture  = 1'b0;
        case (state)
            IDLE: if (cap_ev) begin
                capture  = 1'b1;
                idx_nx   = 3'd0;
                state_nx = SEND;
            end
            SEND: if (hs) begin
                if (idx == 3'd7) begin
                    idx_nx   = 3'd0;
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + 3'd1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            full_q  <= 1'b0;
            idx     <= 3'd0;
            sh_q    <= 4'd0;
            cap_buf <= '0;
            overrun <= 1'b0;
        end else begin
            full_q <= full;
            state  <= state_nx;
            idx    <= idx_nx;
            if (capture) begin
                cap_buf <= acc_in;
                sh_q    <= shift;
            end
            // A fresh edge while a block is still draining is dropped, but remembered.
            if (cap_ev && state != IDLE) overrun <= 1'b1;
        end
    end

    assign wr.out_valid = (state == SEND);
    assign wr.out_addr  = idx;
    assign wr.out_data  = requant(cap_buf[idx], sh_q);
    assign busy         = (state == SEND);
    assign done         = (state == DONE);
endmodule
